clamp_seq64: RTL and testbench
==============================

# clamp_seq64

Sequencer that drives a 64-bit floating-point clamp unit over its sta/done handshake. On a start pulse it reads N_CH double-precision samples from a synchronous channel buffer one at a time. For each sample it issues a single-cycle sta with the sample on x, waits for done, and writes the clamped result back to the buffer. It counts channels whose value was altered by the clamp and flags a timeout if the clamp unit never answers. It sits between the per-channel sample RAM and the threshold/clamp stage in the control datapath.

## Interface
- N_CH, 8: number of channels processed per run (≥1)
- DONE_TIMEOUT, 15: maximum WAIT cycles allowed for clamp_done before failure (≥1)

- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  run request, sampled only in IDLE
- busy  out  1  high whenever state ≠ IDLE
- rd_en  out  1  buffer read strobe; data valid next cycle
- rd_addr  out  clog2(N_CH)  buffer read address
- rd_data  in  64  buffer read data (1-cycle latency)
- clamp_sta  out  1  single-cycle request to clamp unit
- clamp_x  out  64  sample to clamp unit
- clamp_y  in  64  clamped result, valid with clamp_done
- clamp_done  in  1  clamp completion
- wr_en  out  1  buffer write strobe
- wr_addr  out  clog2(N_CH)  write address
- wr_data  out  64  write data
- sat_cnt  out  clog2(N_CH+1)  channels with y ≠ x in current/last run
- done  out  1  one-cycle pulse at end of run (success or fail)
- err  out  1  timeout flag, sticky until next accepted start

## Operation
- States: IDLE, READ, LOAD, ISSUE, WAIT, WRITE, FIN, FAIL.
- IDLE: on start=1, clear ch, sat_cnt and err, then go to READ. start while busy is ignored.
- READ: rd_en=1, rd_addr=ch, then go to LOAD.
- LOAD: x_reg ← rd_data, then go to ISSUE.
- ISSUE: clamp_sta=1 for exactly one cycle, tmr ← 0, then go to WAIT.
- clamp_x = x_reg continuously. It is stable from the cycle after LOAD until x_reg is next loaded.
- WAIT: tmr increments each cycle (first WAIT cycle tmr=1).
  - If clamp_done=1: y_reg ← clamp_y, go to WRITE.
  - Else if tmr==DONE_TIMEOUT: go to FAIL.
- WRITE: wr_en=1, wr_addr=ch, wr_data=y_reg. sat_cnt increments if y_reg ≠ x_reg (bitwise 64-bit compare).
  - If ch==N_CH−1, go to FIN.
  - Else ch ← ch+1 and go to READ.
- FIN: done=1, then go to IDLE.
- FAIL: done=1, err ← 1, then go to IDLE. No write occurs for the timed-out channel. Earlier writes stand.
- clamp_done outside WAIT is ignored. Results do not carry across channels.
- sat_cnt holds its value in IDLE until the next accepted start.

## Timing
- Reset values: busy, rd_en, clamp_sta, wr_en, done, err = 0. rd_addr, wr_addr, clamp_x, wr_data, sat_cnt = 0. State is IDLE.
- All outputs are registered or decoded from registered state, with no combinational path from inputs to outputs.
- Per-channel cost with a clamp unit of 2-cycle done latency (done 2 cycles after sta): READ + LOAD + ISSUE + 2×WAIT + WRITE = 6 cycles.
- Run timing for a start sampled at cycle 0, N_CH=8:
  - ch0 occupies cycles 1–6, with clamp_sta at cycle 3 and wr_en at cycle 6.
  - FIN/done occurs at cycle 49.
  - busy is high for cycles 1–49.
- Timeout: with no clamp_done, FAIL occurs DONE_TIMEOUT+1 cycles after ISSUE.
- Simultaneous clamp_done and tmr==DONE_TIMEOUT: done wins, and the channel is written.
- rst mid-run forces IDLE asynchronously and returns all outputs to reset values. A pending write is dropped.

## Structure
- Shared package holds:
  - the state enum;
  - double constants CLAMP_TOP=64'h403B000000000000 (27.0) and CLAMP_LOW=64'h4000000000000000 (2.0), used by the system and the bench;
  - a clog2-based width helper.
- Single module with no sub-modules. The bench supplies a behavioural clamp model (2-cycle sta→done, configurable latency/no-response) and a 1-cycle-latency RAM model.

## Test plan
- Basic run: RAM = {0x403E000000000000 (30.0), 0x3FF0000000000000 (1.0), 0x4014000000000000 (5.0), five copies of 5.0}, start=1.
  - RAM becomes {27.0, 2.0, 5.0, …}.
  - sat_cnt=2, err=0, done at cycle 49.
- Handshake check: the clamp model asserts that clamp_sta is exactly 1 cycle wide and that clamp_x is stable until clamp_done. Exactly 8 sta pulses and 8 writes occur, at addresses 0..7 in order.
- Timeout: the model never answers for ch3.
  - FAIL is entered 16 cycles after ch3's ISSUE.
  - done=1 and err=1; ch0–2 are written, ch3–7 are untouched, sat_cnt reflects ch0–2 only.
- Edge latency: done arrives exactly at tmr=15, i.e. in the same cycle as the timeout → write occurs, err=0. Then done arrives 16 WAIT cycles after ISSUE → err=1.
- Start while busy: start pulsed at cycles 5 and 20 → ignored, single done pulse. A spurious clamp_done in IDLE/READ → no write.
- Reset mid-run: rst at cycle 25 → all outputs 0 and IDLE immediately. A new start afterwards completes normally with sat_cnt recounted from 0.

Source files
------------

// File: rtl/clamp_seq64_pkg.sv
// Shared definitions for the clamp sequencer and its bench.
//   state_e    : sequencer states
//   CLAMP_TOP  : upper clamp bound (27.0, IEEE-754 double)
//   CLAMP_LOW  : lower clamp bound (2.0, IEEE-754 double)
//   width_of() : clog2-based width that never returns zero
package clamp_seq64_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StLoad,
    StIssue,
    StWait,
    StWrite,
    StFin,
    StFail
  } state_e;

  localparam logic [63:0] CLAMP_TOP = 64'h403B000000000000;
  localparam logic [63:0] CLAMP_LOW = 64'h4000000000000000;

  // Bits needed to hold values 0..n-1; at least one bit.
  function automatic int unsigned width_of(input int unsigned n);
    return (n <= 32'd1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/clamp_seq64.sv
// Sequencer driving a 64-bit floating-point clamp unit over its sta/done handshake.
// Each run reads N_CH samples from a 1-cycle-latency buffer, sends each to the clamp
// unit, writes the result back and counts how many samples the clamp altered.
//   clk, rst             : clock, asynchronous active-high reset
//   start                : run request, honoured only when idle
//   busy                 : high whenever a run is in progress
//   rd_en/rd_addr/rd_data: buffer read port, data returned one cycle after rd_en
//   clamp_sta/clamp_x    : single-cycle request and operand to the clamp unit
//   clamp_y/clamp_done   : clamp result and completion
//   wr_en/wr_addr/wr_data: buffer write port
//   sat_cnt              : channels altered by the clamp in the current/last run
//   done                 : one-cycle end-of-run pulse (success or timeout)
//   err                  : sticky timeout flag, cleared by the next accepted start
module clamp_seq64
  import clamp_seq64_pkg::*;
#(
  parameter int unsigned N_CH         = 8,
  parameter int unsigned DONE_TIMEOUT = 15,
  localparam int unsigned AW = width_of(N_CH),
  localparam int unsigned CW = width_of(N_CH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  input  logic [63:0]   rd_data,
  output logic          clamp_sta,
  output logic [63:0]   clamp_x,
  input  logic [63:0]   clamp_y,
  input  logic          clamp_done,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [63:0]   wr_data,
  output logic [CW-1:0] sat_cnt,
  output logic          done,
  output logic          err
);

  localparam int unsigned TW = width_of(DONE_TIMEOUT + 1);

  state_e          state_q, state_d;
  logic [AW-1:0]   ch_q;
  logic [63:0]     x_q;
  logic [63:0]     y_q;
  logic [TW-1:0]   tmr_q;
  logic [CW-1:0]   sat_q;
  logic            err_q;

  logic [TW-1:0]   tmr_inc;
  logic            timeout_hit;
  logic            last_ch;

  // tmr_inc is the count for the current WAIT cycle: 1 on the first WAIT cycle.
  assign tmr_inc     = tmr_q + TW'(1);
  assign timeout_hit = (tmr_inc == TW'(DONE_TIMEOUT));
  assign last_ch     = (ch_q == AW'(N_CH - 1));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; clamp_done takes priority over the timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (start) state_d = StRead;
      StRead:  state_d = StLoad;
      StLoad:  state_d = StIssue;
      StIssue: state_d = StWait;
      StWait: begin
        if (clamp_done) begin
          state_d = StWrite;
        end else if (timeout_hit) begin
          state_d = StFail;
        end
      end
      StWrite: state_d = last_ch ? StFin : StRead;
      StFin:   state_d = StIdle;
      StFail:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ch_q  <= '0;
      x_q   <= '0;
      y_q   <= '0;
      tmr_q <= '0;
      sat_q <= '0;
      err_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            ch_q  <= '0;
            sat_q <= '0;
            err_q <= 1'b0;
          end
        end
        StLoad:  x_q   <= rd_data;
        StIssue: tmr_q <= '0;
        StWait: begin
          tmr_q <= tmr_inc;
          if (clamp_done) begin
            y_q <= clamp_y;
          end else if (timeout_hit) begin
            // Raised on entry to FAIL so err is already high alongside done.
            err_q <= 1'b1;
          end
        end
        StWrite: begin
          if (y_q != x_q) sat_q <= sat_q + CW'(1);
          if (!last_ch) ch_q <= ch_q + AW'(1);
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from registered state only
  always_comb begin
    busy      = (state_q != StIdle);
    rd_en     = (state_q == StRead);
    clamp_sta = (state_q == StIssue);
    wr_en     = (state_q == StWrite);
    done      = (state_q == StFin) || (state_q == StFail);
  end

  assign rd_addr = ch_q;
  assign wr_addr = ch_q;
  assign clamp_x = x_q;
  assign wr_data = y_q;
  assign sat_cnt = sat_q;
  assign err     = err_q;

endmodule

// File: tb/tb_clamp_seq64.sv
// Bench for clamp_seq64: behavioural clamp unit (configurable latency / silent channel),
// 1-cycle-latency sample RAM, and a run-level reference model.
module tb_clamp_seq64;
  import clamp_seq64_pkg::*;

  localparam int unsigned N_CH         = 8;
  localparam int unsigned DONE_TIMEOUT = 15;
  localparam int unsigned AW           = width_of(N_CH);
  localparam int unsigned CW           = width_of(N_CH + 1);

  logic          clk;
  logic          rst;
  logic          start;
  logic          busy;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [63:0]   rd_data;
  logic          clamp_sta;
  logic [63:0]   clamp_x;
  logic [63:0]   clamp_y = '0;
  logic          clamp_done;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [63:0]   wr_data;
  logic [CW-1:0] sat_cnt;
  logic          done;
  logic          err;

  logic mdl_done = 1'b0;
  logic spur     = 1'b0;
  assign clamp_done = mdl_done | spur;

  clamp_seq64 #(
    .N_CH        (N_CH),
    .DONE_TIMEOUT(DONE_TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .busy      (busy),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .clamp_sta (clamp_sta),
    .clamp_x   (clamp_x),
    .clamp_y   (clamp_y),
    .clamp_done(clamp_done),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .sat_cnt   (sat_cnt),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Real-valued clamp against the package bounds.
  function automatic logic [63:0] ref_clamp(input logic [63:0] x);
    real r;
    r = $bitstoreal(x);
    if (r > $bitstoreal(CLAMP_TOP)) return CLAMP_TOP;
    if (r < $bitstoreal(CLAMP_LOW)) return CLAMP_LOW;
    return x;
  endfunction

  function automatic logic [63:0] rnd_sample();
    int k;
    k = int'($urandom_range(0, 9));
    if (k == 0) return CLAMP_TOP;
    if (k == 1) return CLAMP_LOW;
    return $realtobits((real'($urandom_range(0, 800)) - 400.0) / 10.0);
  endfunction

  // ---------------- sample RAM ----------------
  logic [63:0] ram      [N_CH];
  logic [63:0] init_img [N_CH];
  logic        ld = 1'b0;
  always @(posedge clk) begin
    if (ld) begin
      for (int i = 0; i < N_CH; i++) ram[i] <= init_img[i];
    end else if (wr_en) begin
      ram[wr_addr] <= wr_data;
    end
    if (rd_en) rd_data <= ram[rd_addr];
  end

  // ---------------- clamp unit model ----------------
  int          mdl_lat   = 2;
  int          silent_at = -1;
  int          sta_cnt   = 0;
  int          sta_cyc   = 0;
  int          hs_viol   = 0;
  int          cd        = 0;
  logic        pend      = 1'b0;
  logic        prev_sta  = 1'b0;
  logic [63:0] cap_x     = '0;
  always @(negedge clk) begin
    if (rst) begin
      pend     = 1'b0;
      mdl_done = 1'b0;
      prev_sta = 1'b0;
    end else begin
      mdl_done = 1'b0;
      if (pend) begin
        if (clamp_x !== cap_x) hs_viol++;
        cd--;
        if (cd == 0) begin
          mdl_done = 1'b1;
          clamp_y  = ref_clamp(cap_x);
          pend     = 1'b0;
        end
      end
      if (clamp_sta) begin
        if (prev_sta) hs_viol++;
        if (sta_cnt != silent_at) begin
          pend  = 1'b1;
          cd    = mdl_lat;
          cap_x = clamp_x;
        end
        sta_cnt++;
        sta_cyc = cyc;
      end
      prev_sta = clamp_sta;
    end
  end

  // ---------------- done / write monitor ----------------
  int          done_cnt = 0;
  int          done_cyc = 0;
  int          wr_cnt   = 0;
  logic [AW-1:0] wr_log [4096];
  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (wr_en) begin
      wr_log[wr_cnt] = wr_addr;
      wr_cnt++;
    end
  end

  // ---------------- checking ----------------
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic chk_int(input string tag, input int got, input int want);
    chk(tag, 64'(got), 64'(want));
  endtask

  // Expected outcome of one run
  logic [63:0] exp_ram [N_CH];
  int          exp_sat;
  int          exp_wr;
  int          exp_done_rel;
  logic        exp_err;
  int          w0, d0, st0, s0;

  task automatic prep(input int lat, input int silent_rel);
    int t;
    logic [63:0] y;
    mdl_lat   = lat;
    silent_at = (silent_rel < 0) ? -1 : sta_cnt + silent_rel;
    ld = 1'b1;
    @(negedge clk);
    ld = 1'b0;
    exp_sat = 0;
    exp_wr  = 0;
    exp_err = 1'b0;
    t       = 0;
    for (int ch = 0; ch < N_CH; ch++) exp_ram[ch] = init_img[ch];
    // Each answered channel costs READ+LOAD+ISSUE+WRITE plus lat WAIT cycles.
    for (int ch = 0; ch < N_CH; ch++) begin
      if (ch == silent_rel || lat > int'(DONE_TIMEOUT)) begin
        exp_err      = 1'b1;
        exp_done_rel = t + 3 + int'(DONE_TIMEOUT) + 1;
        break;
      end
      y           = ref_clamp(init_img[ch]);
      exp_ram[ch] = y;
      if (y != init_img[ch]) exp_sat++;
      exp_wr++;
      t += 4 + lat;
    end
    if (!exp_err) exp_done_rel = t + 1;
    w0  = wr_cnt;
    d0  = done_cnt;
    st0 = sta_cnt;
  endtask

  task automatic kick();
    start = 1'b1;
    s0    = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic settle(input string tag);
    int n;
    n = 0;
    while (done_cnt == d0 && n < 3000) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk_int({tag, ":done_cycle"}, done_cyc - s0, exp_done_rel);
    @(negedge clk);
    #1;
    chk_int({tag, ":done_pulses"}, done_cnt - d0, 1);
    chk({tag, ":busy"}, 64'(busy), 64'(0));
    chk({tag, ":err"}, 64'(err), 64'(exp_err));
    chk_int({tag, ":sat_cnt"}, int'(sat_cnt), exp_sat);
    chk_int({tag, ":writes"}, wr_cnt - w0, exp_wr);
    chk_int({tag, ":sta_pulses"}, sta_cnt - st0, exp_wr + (exp_err ? 1 : 0));
    for (int i = 0; i < exp_wr; i++) chk_int({tag, ":wr_order"}, int'(wr_log[w0 + i]), i);
    for (int i = 0; i < N_CH; i++) chk({tag, ":ram"}, ram[i], exp_ram[i]);
  endtask

  task automatic load_basic();
    init_img[0] = 64'h403E000000000000;
    init_img[1] = 64'h3FF0000000000000;
    for (int i = 2; i < N_CH; i++) init_img[i] = 64'h4014000000000000;
  endtask

  task automatic load_random();
    for (int i = 0; i < N_CH; i++) init_img[i] = rnd_sample();
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst:busy", 64'(busy), 64'(0));
    chk("rst:rd_en", 64'(rd_en), 64'(0));
    chk("rst:clamp_sta", 64'(clamp_sta), 64'(0));
    chk("rst:wr_en", 64'(wr_en), 64'(0));
    chk("rst:done", 64'(done), 64'(0));
    chk("rst:err", 64'(err), 64'(0));
    chk("rst:addrs", 64'({rd_addr, wr_addr}), 64'(0));
    chk("rst:clamp_x", clamp_x, 64'(0));
    chk("rst:wr_data", wr_data, 64'(0));
    chk("rst:sat_cnt", 64'(sat_cnt), 64'(0));
    @(negedge clk);
    rst = 1'b0;

    // Spurious clamp_done while idle must not cause a write or a run.
    w0 = wr_cnt;
    d0 = done_cnt;
    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk_int("idle_spur:writes", wr_cnt - w0, 0);
    chk_int("idle_spur:done", done_cnt - d0, 0);
    chk("idle_spur:busy", 64'(busy), 64'(0));

    // Basic run with the reference image.
    load_basic();
    prep(2, -1);
    kick();
    settle("basic");

    // Channel 3 never answered.
    load_random();
    prep(2, 3);
    kick();
    settle("timeout");
    chk_int("timeout:issue_to_fail", done_cyc - sta_cyc, int'(DONE_TIMEOUT) + 1);

    // Answer on the last allowed WAIT cycle, then one cycle too late.
    load_random();
    prep(int'(DONE_TIMEOUT), -1);
    kick();
    settle("edge_ok");
    load_random();
    prep(int'(DONE_TIMEOUT) + 1, -1);
    kick();
    settle("edge_late");

    // Starts while busy and a spurious done in READ are ignored.
    load_random();
    prep(2, -1);
    kick();                           // now in cycle 1
    repeat (4) @(negedge clk);        // cycle 5
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);                   // cycle 7: ch1 READ
    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    repeat (12) @(negedge clk);       // cycle 20
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    settle("busy_start");
    repeat (60) @(negedge clk);
    #1;
    chk_int("busy_start:no_rerun", done_cnt - d0, 1);

    // Reset in the middle of a run, then a clean run.
    load_basic();
    prep(2, -1);
    kick();
    repeat (24) @(negedge clk);       // cycle 25
    rst = 1'b1;
    #1;
    chk("midrst:ctl", 64'({busy, rd_en, clamp_sta, wr_en, done, err, rd_addr, wr_addr, sat_cnt}),
        64'(0));
    chk("midrst:clamp_x", clamp_x, 64'(0));
    chk("midrst:wr_data", wr_data, 64'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    load_basic();
    prep(2, -1);
    kick();
    settle("after_rst");

    // Random images and latencies.
    for (int r = 0; r < 3; r++) begin
      load_random();
      prep(int'($urandom_range(1, 6)), -1);
      kick();
      settle("random");
    end

    chk_int("handshake_violations", hs_viol, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
